// File: rtl/proce_pkg.sv
// Shared defaults and the fetch state encoding for the
// instruction-fetch front end.
package proce_pkg;

  localparam int IW_D       = 8;
  localparam int AW_D       = 8;
  localparam int DEPTH_D    = 4;
  localparam int RESET_PC_D = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/proce_fetch_fifo.sv
// Prefetch buffer: registered synchronous FIFO with clear and
// occupancy; head reads as zero while empty.
module proce_fetch_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (clear) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/proce_fetch_unit.sv
// Instruction-fetch front end: PC, credit-based memory requests,
// prefetch buffer and branch redirect with in-flight drop.
module proce_fetch_unit
  import proce_pkg::*;
#(
  parameter int IW       = IW_D,
  parameter int AW       = AW_D,
  parameter int DEPTH    = DEPTH_D,
  parameter int RESET_PC = RESET_PC_D
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch_en,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ready,
  input  logic          imem_rvalid,
  input  logic [IW-1:0] imem_rdata,
  output logic          ins_valid,
  output logic [IW-1:0] ins_data,
  output logic [AW-1:0] ins_pc,
  input  logic          ins_ready,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e state;
  fetch_state_e state_nxt;

  logic [AW-1:0]    pc;
  logic [AW-1:0]    resp_pc;
  logic [CW-1:0]    outstanding;
  logic [CW-1:0]    drop;
  logic [CW-1:0]    out_nxt;
  logic [CW-1:0]    drop_nxt;
  logic [CW-1:0]    occ;
  logic [CW:0]      inflight;
  logic             credit_ok;
  logic             flushing;
  logic             accept;
  logic             rsp;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [AW+IW-1:0] head;

  // Buffered plus in-flight never exceeds the buffer size.
  assign inflight  = {1'b0, occ} + {1'b0, outstanding};
  assign credit_ok = (inflight < (CW+1)'(DEPTH));

  assign accept = imem_req & imem_ready;
  assign rsp    = imem_rvalid & (outstanding != '0);
  assign push   = rsp & ~flushing & ~redirect & ~fifo_full;
  assign pop    = ins_valid & ins_ready;

  assign imem_addr        = pc;
  assign ins_valid        = ~fifo_empty;
  assign {ins_pc, ins_data} = head;

  always_comb begin
    out_nxt = outstanding + CW'(accept) - CW'(rsp);
  end

  always_comb begin
    drop_nxt = drop;
    if (redirect) begin
      drop_nxt = out_nxt;
    end else if (rsp && flushing) begin
      drop_nxt = drop - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (drop_nxt != '0) state_nxt = FLUSH;
        else if (fetch_en)  state_nxt = RUN;
      end
      RUN: begin
        if (drop_nxt != '0) state_nxt = FLUSH;
        else if (!fetch_en) state_nxt = IDLE;
      end
      FLUSH: begin
        if (drop_nxt == '0) state_nxt = fetch_en ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    flushing = (state == FLUSH);
    imem_req = fetch_en & ~redirect & credit_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= AW'(RESET_PC);
      resp_pc     <= AW'(RESET_PC);
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= out_nxt;
      drop        <= drop_nxt;
      if (redirect) begin
        pc      <= redirect_pc;
        resp_pc <= redirect_pc;
      end else begin
        if (accept) pc      <= pc + AW'(1);
        if (push)   resp_pc <= resp_pc + AW'(1);
      end
    end
  end

  proce_fetch_fifo #(
    .WIDTH (AW + IW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (redirect),
    .push  (push),
    .wdata ({resp_pc, imem_rdata}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (occ)
  );

endmodule
